// File: rtl/diff_line_driver.sv
// diff_line_driver: framed serial byte transmitter driving a slew-limited complementary sample pair
module diff_line_driver #(
  parameter int                BIT_CYCLES = 16,
  parameter logic signed [7:0] AMP        = 8'sd40,
  parameter logic signed [7:0] STEP       = 8'sd10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        data,
  input  logic              valid,
  output logic              ready,
  output logic              busy,
  output logic signed [7:0] ts1,
  output logic signed [7:0] ts2
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic signed [8:0] STEP9 = {STEP[7], STEP};
  state_t            state_q, state_d;
  logic [9:0]        cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shreg_q, shreg_d;
  logic signed [7:0] lvl_q, lvl_d, tgt;
  logic signed [8:0] diff;
  logic              last;
  assign last = cnt_q == 10'(BIT_CYCLES - 1);
  // frame sequencing: bit timing, shift register and the line target per state
  always_comb begin
    state_d = state_q;
    cnt_d   = last ? '0 : cnt_q + 10'd1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tgt     = -AMP;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (valid) begin
          state_d = START;
          shreg_d = data;
          bit_d   = '0;
        end
      end
      START: begin
        tgt = AMP;
        if (last) state_d = DATA;
      end
      DATA: begin
        tgt = shreg_q[0] ? AMP : -AMP;
        if (last) begin
          shreg_d = shreg_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      default: if (last) state_d = IDLE;
    endcase
  end
  assign diff  = $signed({tgt[7], tgt}) - $signed({lvl_q[7], lvl_q});
  assign lvl_d = diff > STEP9 ? lvl_q + STEP : diff < -STEP9 ? lvl_q - STEP : tgt;
  // state registers; reset snaps the line straight to the idle level without ramping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      lvl_q   <= -AMP;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      lvl_q   <= lvl_d;
    end
  end
  assign ready = state_q == IDLE;
  assign busy  = !ready;
  assign ts1   = lvl_q;
  assign ts2   = -lvl_q;
endmodule

// File: tb/tb_diff_line_driver.sv
// tb_diff_line_driver: scoreboard bench over three parameterisations of the line driver
module tb_diff_line_driver;
  localparam int BC = 16;
  localparam int N  = 3;
  logic              clk = 0, rst = 0, valid = 0;
  logic [7:0]        data = 0;
  logic              rdy [N];
  logic              bsy [N];
  logic signed [7:0] t1 [N];
  logic signed [7:0] t2 [N];
  int                checks = 0, errors = 0;
  logic [7:0]        q [$];
  always #5 clk = ~clk;

  diff_line_driver #(.BIT_CYCLES(BC), .AMP(8'sd40), .STEP(8'sd10)) u0 (.clk(clk), .rst(rst), .data(data), .valid(valid),
    .ready(rdy[0]), .busy(bsy[0]), .ts1(t1[0]), .ts2(t2[0]));
  diff_line_driver #(.BIT_CYCLES(BC), .AMP(8'sd40), .STEP(8'sd100)) u1 (.clk(clk), .rst(rst), .data(data), .valid(valid),
    .ready(rdy[1]), .busy(bsy[1]), .ts1(t1[1]), .ts2(t2[1]));
  diff_line_driver #(.BIT_CYCLES(BC), .AMP(8'sd6), .STEP(8'sd1)) u2 (.clk(clk), .rst(rst), .data(data), .valid(valid),
    .ready(rdy[2]), .busy(bsy[2]), .ts1(t1[2]), .ts2(t2[2]));

  function automatic int amp(input int d);
    return d == 2 ? 6 : 40;
  endfunction
  function automatic int stp(input int d);
    return d == 0 ? 10 : d == 1 ? 100 : 1;
  endfunction
  // level j cycles into a bit: starts at prev, closes at most step per clock, then holds tgt
  function automatic int exp_lvl(input int prev, input int tgt, input int step, input int j);
    int dl;
    dl = step * (j - 1);
    if (tgt - prev <= dl && prev - tgt <= dl) return tgt;
    return tgt > prev ? prev + dl : prev - dl;
  endfunction

  task automatic chk(input string name, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t: got %0d expected %0d", name, d, $time, act, exp);
    end
  endtask

  task automatic rst_checks(input string s);
    for (int d = 0; d < N; d++) begin
      chk({s, "_ts1"}, d, t1[d], -amp(d));
      chk({s, "_ts2"}, d, t2[d], amp(d));
      chk({s, "_ready"}, d, rdy[d], 1);
      chk({s, "_busy"}, d, bsy[d], 0);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin @(posedge clk); #1; end
    n = 0;
    while (!rdy[0] && n < 400) begin @(posedge clk); #1; n++; end
    if (!rdy[0]) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: ready stayed %0d, expected 1 within 400 cycles", rdy[0]);
    end else begin
      valid = 1;
      data  = b;
      q.push_back(b);
      @(posedge clk); #1;
      valid = 0;
      data  = 8'($urandom);
    end
  endtask

  task automatic hold(input int n);
    for (int c = 0; c < n; c++) begin
      valid = 1;
      data  = rdy[0] ? 8'h3C : 8'($urandom);
      if (rdy[0]) q.push_back(data);
      @(posedge clk); #1;
    end
    valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int         off = 0;
  bit         act = 0;
  bit         h [N];
  logic [9:0] fb;
  int         bi, bj, e, tg, pv, df;
  always @(negedge clk) begin
    if (!rst) begin
      act = 0;
      for (int d = 0; d < N; d++) h[d] = 0;
    end else begin
      for (int d = 0; d < N; d++) begin
        df = int'(t1[d]) - int'(t2[d]);
        if (df > 5) h[d] = 1;
        else if (df < -5) h[d] = 0;
      end
      if (act) begin
        off++;
        if (off <= 10 * BC) begin
          bi = (off - 1) / BC;
          bj = (off - 1) % BC + 1;
          for (int d = 0; d < N; d++) begin
            tg = fb[bi] ? amp(d) : -amp(d);
            pv = bi == 0 ? -amp(d) : (fb[bi-1] ? amp(d) : -amp(d));
            e  = exp_lvl(pv, tg, stp(d), bj);
            chk("ts1", d, t1[d], e);
            chk("ts2", d, t2[d], -e);
            chk("ready_busy", d, rdy[d], 0);
            chk("busy_frame", d, bsy[d], 1);
            if (bj == BC - 2) chk("decode", d, h[d], fb[bi]);
          end
        end else begin
          for (int d = 0; d < N; d++) begin
            chk("ready_end", d, rdy[d], 1);
            chk("busy_end", d, bsy[d], 0);
          end
          act = 0;
        end
      end
      if (!act) begin
        if (valid && rdy[0]) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL accept: got handshake with empty scoreboard, expected none");
          end else begin
            fb  = {1'b0, q.pop_front(), 1'b1};
            act = 1;
            off = 0;
          end
        end else begin
          for (int d = 0; d < N; d++) begin
            chk("idle_ts1", d, t1[d], -amp(d));
            chk("idle_ready", d, rdy[d], 1);
            chk("idle_busy", d, bsy[d], 0);
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_checks("rst");
    rst = 1;
    send(8'hA5, 0);
    idle(200);
    send(8'h00, 3);
    send(8'hFF, 0);
    idle(200);
    hold(3 * 161 + 10);
    idle(200);
    repeat (6) send(8'($urandom), $urandom_range(0, 5));
    send(8'h01, 2);
    send(8'($urandom), 2);
    repeat (50) @(posedge clk);
    #3 rst = 0;
    #1 rst_checks("async_rst");
    q.delete();
    @(posedge clk);
    #1 rst = 1;
    send(8'($urandom), 1);
    idle(200);
    chk("queue_empty", 0, q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
